// File: rtl/data_memory_stage.sv
// Memory-access stage of the 16-bit MIPS pipeline: word-addressed data RAM with
// configurable wait states, load/store range checking and ALU pass-through.
module data_memory_stage #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [15:0] ans_ex,
    input  logic [15:0] b_data,
    input  logic        mem_rd,
    input  logic        mem_wr,
    output logic        stall,
    output logic [15:0] ans_dm,
    output logic        valid_dm,
    output logic        addr_err
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);
    localparam int         DEPTH     = 2 ** ADDR_W;

    state_t      state;
    logic [2:0]  cnt;
    logic [15:0] ans_q;
    logic [15:0] data_q;
    logic        rd_q;
    logic        wr_q;

    logic [15:0] ram [DEPTH];

    logic [15:0] sel_ans;
    logic [15:0] sel_data;
    logic        sel_rd;
    logic        sel_wr;
    logic        is_mem;
    logic        is_load;
    logic        out_of_range;
    logic        accept;
    logic        complete;
    logic        ram_we;
    logic [15:0] rd_word;
    logic [15:0] result;

    // An op completing on its accept edge uses the live inputs; one completing
    // out of WAIT uses the copy captured at accept time.
    always_comb begin
        sel_ans      = ans_ex;
        sel_data     = b_data;
        sel_rd       = mem_rd;
        sel_wr       = mem_wr;
        if (state == WAIT) begin
            sel_ans  = ans_q;
            sel_data = data_q;
            sel_rd   = rd_q;
            sel_wr   = wr_q;
        end
        is_mem       = sel_rd | sel_wr;
        is_load      = sel_rd & ~sel_wr;
        out_of_range = |sel_ans[15:ADDR_W];
        accept       = (state == IDLE) && valid_in;
        complete     = (accept && (!is_mem || WAIT_CYCLES == 0)) ||
                       ((state == WAIT) && (cnt == 3'd1));
        ram_we       = reset && complete && sel_wr && !out_of_range;
        rd_word      = ram[sel_ans[ADDR_W-1:0]];
        result       = 16'h0000;
        if (!is_mem)
            result = sel_ans;
        else if (is_load && !out_of_range)
            result = rd_word;
    end

    assign stall = (state == WAIT);

    // RAM has no reset; contents survive a reset and are undefined until written.
    always_ff @(posedge clk) begin
        if (ram_we)
            ram[sel_ans[ADDR_W-1:0]] <= sel_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            ans_q    <= 16'h0000;
            data_q   <= 16'h0000;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            ans_dm   <= 16'h0000;
            valid_dm <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            valid_dm <= 1'b0;
            addr_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        ans_q  <= ans_ex;
                        data_q <= b_data;
                        rd_q   <= mem_rd;
                        wr_q   <= mem_wr;
                        if (is_mem && WAIT_CYCLES != 0) begin
                            state <= WAIT;
                            cnt   <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (complete) begin
                valid_dm <= 1'b1;
                addr_err <= is_mem & out_of_range;
                ans_dm   <= result;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_stage.sv
// Bench for data_memory_stage: four instances with WAIT_CYCLES 0..3 driven one
// at a time; a scoreboard queue holds the expected result and completion cycle.
module tb_data_memory_stage;

    localparam int NINST = 4;

    logic        clk;
    logic        reset;
    logic        valid_in [NINST];
    logic [15:0] ans_ex   [NINST];
    logic [15:0] b_data   [NINST];
    logic        mem_rd   [NINST];
    logic        mem_wr   [NINST];
    logic        stall    [NINST];
    logic [15:0] ans_dm   [NINST];
    logic        valid_dm [NINST];
    logic        addr_err [NINST];

    for (genvar g = 0; g < NINST; g++) begin : g_dut
        data_memory_stage #(.ADDR_W(8), .WAIT_CYCLES(g)) u_dut (
            .clk      (clk),
            .reset    (reset),
            .valid_in (valid_in[g]),
            .ans_ex   (ans_ex[g]),
            .b_data   (b_data[g]),
            .mem_rd   (mem_rd[g]),
            .mem_wr   (mem_wr[g]),
            .stall    (stall[g]),
            .ans_dm   (ans_dm[g]),
            .valid_dm (valid_dm[g]),
            .addr_err (addr_err[g])
        );
    end

    typedef struct {
        logic [15:0] ans;
        logic        err;
        int          due;
    } exp_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic        rd;
        logic        wr;
        logic [15:0] exp_ans;
        logic        exp_err;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[12];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   cur   = 1;
    int   stall0_cnt = 0;
    int   run0 = 0;
    int   run0_max = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every valid_dm pulse on the active instance must match the
    // oldest expectation, including the cycle it was due.
    always @(negedge clk) begin
        if (reset) begin
            if (valid_dm[cur]) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_valid: inst %0d ans_dm %h at cycle %0d", cur, ans_dm[cur], cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    checkOutput("ans_dm", 32'(ans_dm[cur]), 32'(e.ans));
                    checkOutput("addr_err", 32'(addr_err[cur]), 32'(e.err));
                    checkOutput("latency_cycle", 32'(cyc), 32'(e.due));
                end
            end else if (sbq.size() > 0 && cyc > sbq[0].due) begin
                tests++;
                fails++;
                $display("[TB] FAIL missing_valid: inst %0d due cycle %0d, now %0d", cur, sbq[0].due, cyc);
                void'(sbq.pop_front());
            end
            if (stall[0]) stall0_cnt++;
            if (valid_dm[0]) begin
                run0++;
                if (run0 > run0_max) run0_max = run0;
            end else begin
                run0 = 0;
            end
        end
    end

    task automatic applyStimulus(input int k, input logic [15:0] addr, input logic [15:0] data,
                                 input logic rd, input logic wr,
                                 input logic [15:0] exp_ans, input logic exp_err);
        exp_t e;
        int   n;
        @(negedge clk);
        cur         = k;
        valid_in[k] = 1'b1;
        ans_ex[k]   = addr;
        b_data[k]   = data;
        mem_rd[k]   = rd;
        mem_wr[k]   = wr;
        n = 0;
        while (stall[k] === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) begin
            tests++;
            fails++;
            $display("[TB] FAIL stall_timeout: inst %0d stall never dropped", k);
        end
        e.ans = exp_ans;
        e.err = exp_err;
        e.due = cyc + 1 + ((rd | wr) ? k : 0);
        sbq.push_back(e);
        @(posedge clk);
        #1 valid_in[k] = 1'b0;
    endtask

    task automatic check_stall(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput("stall_high", 32'(stall[k]), 32'd1);
        end
        @(negedge clk);
        checkOutput("stall_low", 32'(stall[k]), 32'd0);
    endtask

    task automatic drain(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{16'h1234, 16'h0000, 1'b0, 1'b0, 16'h1234, 1'b0};
        vecs[1]  = '{16'h0005, 16'hBEEF, 1'b0, 1'b1, 16'h0000, 1'b0};
        vecs[2]  = '{16'h0005, 16'h0000, 1'b1, 1'b0, 16'hBEEF, 1'b0};
        vecs[3]  = '{16'h0105, 16'h1111, 1'b0, 1'b1, 16'h0000, 1'b1};
        vecs[4]  = '{16'h0005, 16'h0000, 1'b1, 1'b0, 16'hBEEF, 1'b0};
        vecs[5]  = '{16'h0105, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1};
        vecs[6]  = '{16'h0020, 16'h5A5A, 1'b1, 1'b1, 16'h0000, 1'b0};
        vecs[7]  = '{16'h0020, 16'h0000, 1'b1, 1'b0, 16'h5A5A, 1'b0};
        vecs[8]  = '{16'h8000, 16'h7777, 1'b1, 1'b1, 16'h0000, 1'b1};
        vecs[9]  = '{16'h00FF, 16'h0F0F, 1'b0, 1'b1, 16'h0000, 1'b0};
        vecs[10] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0F0F, 1'b0};
        vecs[11] = '{16'h0100, 16'h0000, 1'b0, 1'b0, 16'h0100, 1'b0};

        for (int i = 0; i < NINST; i++) begin
            valid_in[i] = 1'b0;
            ans_ex[i]   = 16'h0000;
            b_data[i]   = 16'h0000;
            mem_rd[i]   = 1'b0;
            mem_wr[i]   = 1'b0;
        end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ans_dm", 32'(ans_dm[1]), 32'h0);
        checkOutput("reset_stall", 32'(stall[1]), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // WAIT_CYCLES=1: table of loads, stores and pass-through ops
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1, vecs[i].addr, vecs[i].data, vecs[i].rd, vecs[i].wr,
                          vecs[i].exp_ans, vecs[i].exp_err);
            if (vecs[i].rd | vecs[i].wr) check_stall(1, 1);
        end
        drain(3);

        // Asynchronous reset mid-cycle with random inputs applied
        @(posedge clk);
        #2;
        valid_in[1] = 1'b1;
        ans_ex[1]   = 16'($urandom);
        b_data[1]   = 16'($urandom);
        mem_rd[1]   = 1'($urandom);
        mem_wr[1]   = 1'($urandom);
        #1 reset = 1'b0;
        #1;
        checkOutput("async_reset_ans_dm", 32'(ans_dm[1]), 32'h0);
        checkOutput("async_reset_valid_dm", 32'(valid_dm[1]), 32'h0);
        checkOutput("async_reset_addr_err", 32'(addr_err[1]), 32'h0);
        checkOutput("async_reset_stall", 32'(stall[1]), 32'h0);
        @(negedge clk);
        valid_in[1] = 1'b0;
        reset = 1'b1;
        applyStimulus(1, 16'h1234, 16'h0000, 1'b0, 1'b0, 16'h1234, 1'b0);
        applyStimulus(1, 16'h0005, 16'h0000, 1'b1, 1'b0, 16'hBEEF, 1'b0);
        check_stall(1, 1);
        drain(2);

        // WAIT_CYCLES=3: reset during the second WAIT cycle aborts a store
        applyStimulus(3, 16'h0010, 16'h1111, 1'b0, 1'b1, 16'h0000, 1'b0);
        check_stall(3, 3);
        @(negedge clk);
        valid_in[3] = 1'b1;
        ans_ex[3]   = 16'h0010;
        b_data[3]   = 16'hAAAA;
        mem_rd[3]   = 1'b0;
        mem_wr[3]   = 1'b1;
        @(posedge clk);
        #1 valid_in[3] = 1'b0;
        @(negedge clk);
        checkOutput("wait3_stall_first", 32'(stall[3]), 32'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("midwait_reset_stall", 32'(stall[3]), 32'h0);
        checkOutput("midwait_reset_ans_dm", 32'(ans_dm[3]), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("aborted_no_valid", 32'(valid_dm[3]), 32'h0);
        end
        applyStimulus(3, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h1111, 1'b0);
        check_stall(3, 3);
        drain(2);

        // WAIT_CYCLES=2: back-pressure; inputs wiggled during stall are ignored
        applyStimulus(2, 16'h0030, 16'h3030, 1'b0, 1'b1, 16'h0000, 1'b0);
        check_stall(2, 2);
        applyStimulus(2, 16'h0030, 16'h0000, 1'b1, 1'b0, 16'h3030, 1'b0);
        @(negedge clk);
        checkOutput("bp_stall_1", 32'(stall[2]), 32'd1);
        valid_in[2] = 1'b1;
        ans_ex[2]   = 16'h7777;
        mem_rd[2]   = 1'b0;
        mem_wr[2]   = 1'b0;
        @(negedge clk);
        checkOutput("bp_stall_2", 32'(stall[2]), 32'd1);
        ans_ex[2]   = 16'h0030;
        b_data[2]   = 16'hDEAD;
        mem_wr[2]   = 1'b1;
        @(posedge clk);
        #1 valid_in[2] = 1'b0;
        applyStimulus(2, 16'h7777, 16'h0000, 1'b0, 1'b0, 16'h7777, 1'b0);
        applyStimulus(2, 16'h0030, 16'h0000, 1'b1, 1'b0, 16'h3030, 1'b0);
        check_stall(2, 2);
        drain(2);

        // WAIT_CYCLES=0: back-to-back memory ops, never stalling
        stall0_cnt = 0;
        run0_max   = 0;
        applyStimulus(0, 16'h0040, 16'h4444, 1'b0, 1'b1, 16'h0000, 1'b0);
        applyStimulus(0, 16'h0040, 16'h0000, 1'b1, 1'b0, 16'h4444, 1'b0);
        applyStimulus(0, 16'h0041, 16'h4141, 1'b0, 1'b1, 16'h0000, 1'b0);
        applyStimulus(0, 16'h0041, 16'h0000, 1'b1, 1'b0, 16'h4141, 1'b0);
        drain(3);
        checkOutput("wc0_stall_cycles", 32'(stall0_cnt), 32'd0);
        checkOutput("wc0_consecutive_valid", 32'(run0_max), 32'd4);

        drain(2);
        checkOutput("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
